// File: rtl/mul_arb_pkg.sv
// Shared types and constants for the multiplier arbiter.
//   state_t : arbiter FSM states (IDLE/ISSUE/WAIT/RESP)
//   DEF_*   : default parameter values
//   idx_w() : width of a binary requester index
package mul_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_NREQ  = 2;

    // Binary index width for n requesters (at least one bit).
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mul_arbiter_rr.sv
// Round-robin priority picker: first set request at or after ptr, wrapping.
//   req   : request vector
//   ptr   : highest-priority requester index
//   grant : one-hot winner (zero when no request)
//   idx   : binary winner index
//   any   : at least one request set
module rr_arbiter
    import mul_arb_pkg::*;
#(
    parameter int unsigned NREQ = DEF_NREQ,
    parameter int unsigned IW   = idx_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   idx,
    output logic            any
);

    int unsigned cand;

    // Scan from ptr upward, modulo NREQ; first hit wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = (32'(ptr) + i) % NREQ;
            if (!any && req[IW'(cand)]) begin
                any               = 1'b1;
                idx               = IW'(cand);
                grant[IW'(cand)]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mul_arbiter.sv
// Shares one iterative multiplier core among NREQ requesters with
// round-robin arbitration and a valid/ready response channel.
// Optional watchdog: define MUL_ARB_TIMEOUT_EN to abort WAIT after TIMEOUT
// cycles with rsp_err=1 and rsp_data=0.
//   clk, rst              : clock, async active-high reset
//   req_valid/req_ready   : operand request handshake (req_ready one-hot, comb)
//   req_a, req_b          : per-requester operands, slice k = requester k
//   rsp_valid/rsp_ready   : result handshake (rsp_valid one-hot)
//   rsp_data, rsp_err     : product and watchdog-abort flag
//   busy                  : FSM not idle
//   mul_start/a/b         : core start pulse and registered operands
//   mul_done/mul_product  : core completion pulse and result
module mul_arbiter
    import mul_arb_pkg::*;
#(
    parameter int unsigned NREQ    = DEF_NREQ,
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned TIMEOUT = 40
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*WIDTH-1:0]  req_a,
    input  logic [NREQ*WIDTH-1:0]  req_b,
    output logic [NREQ-1:0]        rsp_valid,
    input  logic [NREQ-1:0]        rsp_ready,
    output logic [2*WIDTH-1:0]     rsp_data,
    output logic                   rsp_err,
    output logic                   busy,
    output logic                   mul_start,
    output logic [WIDTH-1:0]       mul_a,
    output logic [WIDTH-1:0]       mul_b,
    input  logic                   mul_done,
    input  logic [2*WIDTH-1:0]     mul_product
);

    localparam int unsigned IW = idx_w(NREQ);
    localparam int unsigned PW = 2 * WIDTH;

    // Elaboration-time parameter sanity.
    if (NREQ < 2 || TIMEOUT < 1) begin : g_bad_params
        $error("mul_arbiter: requires NREQ >= 2 and TIMEOUT >= 1");
    end

    state_t           state, state_nxt;
    logic [IW-1:0]    ptr, ptr_nxt;
    logic [IW-1:0]    g, g_nxt;
    logic [WIDTH-1:0] a_nxt, b_nxt;
    logic [PW-1:0]    data_nxt;

    logic [NREQ-1:0]  arb_grant;
    logic [IW-1:0]    arb_idx;
    logic             arb_any;

    logic [WIDTH-1:0] a_arr [NREQ];
    logic [WIDTH-1:0] b_arr [NREQ];

`ifdef MUL_ARB_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt, cnt_nxt;
    logic          err_nxt;
`else
    assign rsp_err = 1'b0;
`endif

    // Unpack flat operand buses into per-requester views.
    for (genvar k = 0; k < NREQ; k++) begin : g_unpack
        assign a_arr[k] = req_a[k*WIDTH +: WIDTH];
        assign b_arr[k] = req_b[k*WIDTH +: WIDTH];
    end

    rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (arb_grant),
        .idx   (arb_idx),
        .any   (arb_any)
    );

    // Decodes of registered state.
    assign req_ready = (state == IDLE) ? arb_grant : '0;
    assign rsp_valid = (state == RESP) ? (NREQ'(1) << g) : '0;
    assign mul_start = (state == ISSUE);
    assign busy      = (state != IDLE);

    // Next-state and register update values.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        g_nxt     = g;
        a_nxt     = mul_a;
        b_nxt     = mul_b;
        data_nxt  = rsp_data;
`ifdef MUL_ARB_TIMEOUT_EN
        cnt_nxt   = cnt;
        err_nxt   = rsp_err;
`endif
        unique case (state)
            IDLE: begin
                if (arb_any) begin
                    g_nxt     = arb_idx;
                    a_nxt     = a_arr[arb_idx];
                    b_nxt     = b_arr[arb_idx];
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                state_nxt = WAIT;
`ifdef MUL_ARB_TIMEOUT_EN
                cnt_nxt   = '0;
`endif
            end
            WAIT: begin
                if (mul_done) begin
                    data_nxt  = mul_product;
                    state_nxt = RESP;
`ifdef MUL_ARB_TIMEOUT_EN
                    err_nxt   = 1'b0;
`endif
                end
`ifdef MUL_ARB_TIMEOUT_EN
                // Last permitted WAIT cycle without done: abort.
                else if (cnt == CW'(TIMEOUT - 1)) begin
                    data_nxt  = '0;
                    err_nxt   = 1'b1;
                    state_nxt = RESP;
                end else begin
                    cnt_nxt   = cnt + 1'b1;
                end
`endif
            end
            RESP: begin
                if (rsp_ready[g]) begin
                    ptr_nxt   = (g == IW'(NREQ - 1)) ? '0 : g + 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            g        <= '0;
            mul_a    <= '0;
            mul_b    <= '0;
            rsp_data <= '0;
`ifdef MUL_ARB_TIMEOUT_EN
            cnt      <= '0;
            rsp_err  <= 1'b0;
`endif
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            g        <= g_nxt;
            mul_a    <= a_nxt;
            mul_b    <= b_nxt;
            rsp_data <= data_nxt;
`ifdef MUL_ARB_TIMEOUT_EN
            cnt      <= cnt_nxt;
            rsp_err  <= err_nxt;
`endif
        end
    end

endmodule
